wb_bridge: RTL



---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_addr_decode.sv | 29 ++
 rtl/wb_bridge.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone bridge and its address decoder.
// Holds the bridge state encoding, the bus data/select widths, the default
// slave-select bit position and a helper for the select-field width.
package wb_pkg;

  localparam int WB_DATA_W   = 32;
  localparam int WB_SEL_W    = 4;
  localparam int DEF_SEL_LSB = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width of the slave-select field; a single slave still needs one bit.
  function automatic int sel_width(input int num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: splits a core byte address into a slave index
// and flags a miss when the index has no slave behind it or any address bit
// above the select field is set. Kept separate so a second master can reuse it.
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = DEF_SEL_LSB,
  parameter int SEL_W      = sel_width(NUM_SLAVES)
) (
  input  logic [31:0]      addr,
  output logic [SEL_W-1:0] idx,
  output logic             miss
);

  logic [31:0] upper_bits;
  logic [31:0] idx_ext;

  // Extract the select field and check both miss conditions.
  // NOTE: every output of a combinational block gets a value on every path
  // (here unconditionally at the top), otherwise synthesis infers a latch.
  always_comb begin
    idx        = addr[SEL_LSB +: SEL_W];
    upper_bits = addr >> (SEL_LSB + SEL_W);
    idx_ext    = 32'(idx);
    miss       = (upper_bits != '0) || (idx_ext >= 32'(NUM_SLAVES));
  end

endmodule

// File: rtl/wb_bridge.sv
// Load/store port to Wishbone Classic bridge with one outstanding transaction.
// The address selects one of NUM_SLAVES windows, each driven by its own cycle
// line; strobe, write enable, selects, address and write data are shared.
// Optional build macro WB_TIMEOUT_EN: a watchdog ends a bus cycle with an error
// after TIMEOUT_CYC cycles without acknowledge. Without it the bridge waits
// for the acknowledge indefinitely.
module wb_bridge
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int SEL_LSB     = DEF_SEL_LSB,
  parameter int WB_ADR_W    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  // core load/store port
  input  logic                            mem_req,
  input  logic                            mem_we,
  input  logic [31:0]                     mem_addr,
  input  logic [WB_SEL_W-1:0]             mem_be,
  input  logic [WB_DATA_W-1:0]            mem_wdata,
  output logic [WB_DATA_W-1:0]            mem_rdata,
  output logic                            mem_ready,
  output logic                            mem_err,
  // Wishbone master side
  output logic [NUM_SLAVES-1:0]           wb_cyc_o,
  output logic                            wb_stb_o,
  output logic                            wb_we_o,
  output logic [WB_SEL_W-1:0]             wb_sel_o,
  output logic [WB_ADR_W-1:0]             wb_adr_o,
  output logic [WB_DATA_W-1:0]            wb_dat_o,
  input  logic [WB_DATA_W*NUM_SLAVES-1:0] wb_dat_i,
  input  logic [NUM_SLAVES-1:0]           wb_ack_i
);

  localparam int SEL_W = sel_width(NUM_SLAVES);

  state_t                 state;
  logic [SEL_W-1:0]       dec_idx;
  logic                   dec_miss;
  logic [SEL_W-1:0]       cur_idx;
  logic [NUM_SLAVES-1:0]  req_onehot;
  logic                   cur_ack;
  logic [WB_DATA_W-1:0]   cur_rdata;

`ifdef WB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // The last counted BUS cycle is the TIMEOUT_CYC-th one.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  // The timeout length only matters when the watchdog is built in.
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_LSB    (SEL_LSB),
    .SEL_W      (SEL_W)
  ) u_decode (
    .addr (mem_addr),
    .idx  (dec_idx),
    .miss (dec_miss)
  );

  // One-hot cycle line for the incoming request, plus the ack and read data
  // of the slave owning the current transaction; other slaves are ignored.
  always_comb begin
    req_onehot = '0;
    cur_ack    = 1'b0;
    cur_rdata  = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (dec_idx == SEL_W'(k)) begin
        req_onehot[k] = 1'b1;
      end
      if (cur_idx == SEL_W'(k)) begin
        cur_ack   = wb_ack_i[k];
        cur_rdata = wb_dat_i[WB_DATA_W*k +: WB_DATA_W];
      end
    end
  end

  // Transaction FSM with registered bus and response outputs.
  // NOTE: state and outputs are updated with non-blocking assignments so every
  // register samples the pre-edge values; blocking here would create ordering
  // races between the reads and writes inside this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_idx   <= '0;
      wb_cyc_o  <= '0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
`ifdef WB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      // Completion is a single-cycle pulse unless a branch below raises it.
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;

      unique case (state)
        IDLE: begin
          // While a miss response is showing, the core still holds its
          // request; it must not be taken as a new one.
          if (mem_req && !mem_ready) begin
            if (dec_miss) begin
              mem_ready <= 1'b1;
              mem_err   <= 1'b1;
              mem_rdata <= '0;
            end else begin
              cur_idx  <= dec_idx;
              wb_cyc_o <= req_onehot;
              wb_stb_o <= 1'b1;
              wb_we_o  <= mem_we;
              wb_sel_o <= mem_be;
              wb_adr_o <= mem_addr[WB_ADR_W+1:2];
              wb_dat_o <= mem_wdata;
`ifdef WB_TIMEOUT_EN
              tmo_cnt  <= '0;
`endif
              state    <= BUS;
            end
          end
        end

        BUS: begin
          // The ack takes priority over a watchdog expiry in the same cycle.
          if (cur_ack) begin
            wb_cyc_o  <= '0;
            wb_stb_o  <= 1'b0;
            mem_rdata <= wb_we_o ? '0 : cur_rdata;
            mem_ready <= 1'b1;
            state     <= RESP;
          end
`ifdef WB_TIMEOUT_EN
          else if (tmo_hit) begin
            wb_cyc_o  <= '0;
            wb_stb_o  <= 1'b0;
            mem_rdata <= '0;
            mem_ready <= 1'b1;
            mem_err   <= 1'b1;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        // mem_ready is high for this one cycle; the core drops its request
        // on the closing edge, so nothing is accepted here.
        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
